// File: rtl/interp_tile_walker.sv
// Walks one TILE_W x TILE_H tile per polygon and re-arms the interpolator setup on every row.
// Streams one captured pixel per cycle when unstalled; a stalled output register freezes x_ps and the counters.
module interp_tile_walker #(
  parameter int TILE_W     = 32,
  parameter int TILE_H     = 32,
  parameter int SETUP_WAIT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               poly_valid,
  output logic               poly_ready,
  input  logic [10:0]        tile_x_base,
  input  logic [10:0]        tile_y_base,
  output logic               setup,
  output logic [10:0]        x_ps,
  output logic [10:0]        y_ps,
  input  logic signed [31:0] interp_in,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [4:0]         pix_col,
  output logic [4:0]         pix_row,
  output logic signed [31:0] pix_z,
  output logic               pix_last,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, SCAN, DRAIN} state_t;

  localparam logic [4:0] COL_LAST  = 5'(TILE_W - 1);
  localparam logic [4:0] ROW_LAST  = 5'(TILE_H - 1);
  localparam logic [2:0] WAIT_LAST = 3'((SETUP_WAIT > 0) ? SETUP_WAIT - 1 : 0);

  state_t             state_q, state_d;
  logic [10:0]        base_x_q, base_x_d;
  logic [10:0]        base_y_q, base_y_d;
  logic [4:0]         col_q, col_d;
  logic [4:0]         row_q, row_d;
  logic [2:0]         wait_q, wait_d;
  logic               pix_valid_q, pix_valid_d;
  logic               pix_last_q, pix_last_d;
  logic [4:0]         pix_col_q, pix_col_d;
  logic [4:0]         pix_row_q, pix_row_d;
  logic signed [31:0] pix_z_q, pix_z_d;
  logic               capture;
  logic               out_accept;

  always_comb begin
    state_d     = state_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    col_d       = col_q;
    row_d       = row_q;
    wait_d      = wait_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    pix_z_d     = pix_z_q;
    capture     = 1'b0;
    out_accept  = pix_valid_q && pix_ready;

    case (state_q)
      IDLE: begin
        if (poly_valid) begin
          base_x_d = tile_x_base;
          base_y_d = tile_y_base;
          col_d    = '0;
          row_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = (SETUP_WAIT > 0) ? SETTLE : SCAN;
      end
      SETTLE: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = SCAN;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      SCAN: begin
        // Counters only advance on a capture, so a stall holds x_ps steady.
        if (!pix_valid_q || pix_ready) begin
          capture = 1'b1;
          if (col_q != COL_LAST) begin
            col_d = col_q + 5'd1;
          end else if (row_q != ROW_LAST) begin
            col_d   = '0;
            row_d   = row_q + 5'd1;
            state_d = SETUP;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      pix_valid_d = 1'b1;
      pix_z_d     = interp_in;
      pix_col_d   = col_q;
      pix_row_d   = row_q;
      pix_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end else if (out_accept) begin
      pix_valid_d = 1'b0;
      pix_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_x_q    <= '0;
      base_y_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wait_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      pix_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wait_q      <= wait_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      pix_z_q     <= pix_z_d;
    end
  end

  // Coordinates wrap modulo 2048; col is zero during SETUP so x_ps is the base there.
  assign x_ps       = base_x_q + {6'd0, col_q};
  assign y_ps       = base_y_q + {6'd0, row_q};
  assign setup      = (state_q == SETUP);
  assign poly_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign pix_valid  = pix_valid_q;
  assign pix_last   = pix_last_q;
  assign pix_col    = pix_col_q;
  assign pix_row    = pix_row_q;
  assign pix_z      = pix_z_q;

endmodule

// File: tb/tb_interp_tile_walker.sv
// Directed bench for interp_tile_walker: a 32x32/SETUP_WAIT=1 instance and an 8x4/SETUP_WAIT=3 instance.
module tb_interp_tile_walker;

  logic clock;
  logic reset_n;

  logic               poly_valid_a, poly_ready_a, setup_a, pix_valid_a, pix_ready_a, pix_last_a, busy_a;
  logic [10:0]        tile_x_base_a, tile_y_base_a, x_ps_a, y_ps_a, yreg_a;
  logic signed [31:0] interp_a, pix_z_a;
  logic [4:0]         pix_col_a, pix_row_a;

  logic               poly_valid_b, poly_ready_b, setup_b, pix_valid_b, pix_ready_b, pix_last_b, busy_b;
  logic [10:0]        tile_x_base_b, tile_y_base_b, x_ps_b, y_ps_b, yreg_b;
  logic signed [31:0] interp_b, pix_z_b;
  logic [4:0]         pix_col_b, pix_row_b;

  int checks;
  int errors;

  interp_tile_walker #(.TILE_W(32), .TILE_H(32), .SETUP_WAIT(1)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .poly_valid(poly_valid_a), .poly_ready(poly_ready_a),
    .tile_x_base(tile_x_base_a), .tile_y_base(tile_y_base_a),
    .setup(setup_a), .x_ps(x_ps_a), .y_ps(y_ps_a), .interp_in(interp_a),
    .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_col(pix_col_a),
    .pix_row(pix_row_a), .pix_z(pix_z_a), .pix_last(pix_last_a), .busy(busy_a)
  );

  interp_tile_walker #(.TILE_W(8), .TILE_H(4), .SETUP_WAIT(3)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .poly_valid(poly_valid_b), .poly_ready(poly_ready_b),
    .tile_x_base(tile_x_base_b), .tile_y_base(tile_y_base_b),
    .setup(setup_b), .x_ps(x_ps_b), .y_ps(y_ps_b), .interp_in(interp_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_col(pix_col_b),
    .pix_row(pix_row_b), .pix_z(pix_z_b), .pix_last(pix_last_b), .busy(busy_b)
  );

  // Interpolator model: y term registered on setup, x term combinational.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      yreg_a <= '0;
      yreg_b <= '0;
    end else begin
      if (setup_a) yreg_a <= y_ps_a;
      if (setup_b) yreg_b <= y_ps_b;
    end
  end
  assign interp_a = $signed(32'd3 * {21'd0, x_ps_a} + 32'd1000 * {21'd0, yreg_a});
  assign interp_b = $signed(32'd3 * {21'd0, x_ps_b} + 32'd1000 * {21'd0, yreg_b});

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b1;
    poly_valid_a = 1'b0; pix_ready_a = 1'b1; tile_x_base_a = '0; tile_y_base_a = '0;
    poly_valid_b = 1'b0; pix_ready_b = 1'b1; tile_x_base_b = '0; tile_y_base_b = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (setup_a !== 1'b0 || pix_valid_a !== 1'b0 || pix_last_a !== 1'b0 || busy_a !== 1'b0 ||
        poly_ready_a !== 1'b1 || x_ps_a !== 11'd0 || y_ps_a !== 11'd0 || pix_col_a !== 5'd0 ||
        pix_row_a !== 5'd0 || pix_z_a !== 32'sd0) begin
      errors++;
      $display("FAIL reset_state: setup=%b valid=%b last=%b busy=%b prdy=%b x=%0d y=%0d col=%0d row=%0d z=%0d, want 0 0 0 0 1 0 0 0 0 0",
               setup_a, pix_valid_a, pix_last_a, busy_a, poly_ready_a, x_ps_a, y_ps_a, pix_col_a, pix_row_a, pix_z_a);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (poly_ready_b !== 1'b1 || busy_b !== 1'b0 || pix_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_b: prdy=%b busy=%b valid=%b want 1 0 0", poly_ready_b, busy_b, pix_valid_b);
    end
  endtask

  // Walks one tile on instance A, checking order, values, stalls and setup pulses.
  task automatic walk_tile(input int bx, input int by, input bit rnd, input int exp_cycles);
    int edges, setups, got, ec, er, ez;
    bit prev_stall, done;
    logic [10:0] prev_x;
    logic signed [31:0] prev_z;
    @(negedge clock);
    tile_x_base_a = 11'(bx); tile_y_base_a = 11'(by); poly_valid_a = 1'b1; pix_ready_a = 1'b1;
    checks++;
    if (poly_ready_a !== 1'b1) begin
      errors++; $display("FAIL walk_poly_ready: got %b want 1", poly_ready_a);
    end
    @(negedge clock);
    poly_valid_a = 1'b0; tile_x_base_a = 11'd5; tile_y_base_a = 11'd9;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL walk_accept_busy: got %b want 1", busy_a);
    end
    edges = 0; setups = 0; got = 0; done = 0; prev_stall = 0; prev_x = '0; prev_z = '0;
    while (!done) begin
      pix_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        checks++;
        if (pix_valid_a !== 1'b1 || x_ps_a !== prev_x || pix_z_a !== prev_z) begin
          errors++;
          $display("FAIL stall_hold: valid=%b x=%0d z=%0d want 1 x=%0d z=%0d", pix_valid_a, x_ps_a, pix_z_a, prev_x, prev_z);
        end
      end
      if (setup_a) begin
        setups++;
        checks++;
        if (y_ps_a !== 11'(by + setups - 1) || x_ps_a !== 11'(bx)) begin
          errors++;
          $display("FAIL setup_coords: x=%0d y=%0d want x=%0d y=%0d", x_ps_a, y_ps_a, 11'(bx), 11'(by + setups - 1));
        end
      end
      if (pix_valid_a && pix_ready_a) begin
        ec = got % 32; er = got / 32;
        ez = 3 * ((bx + ec) % 2048) + 1000 * ((by + er) % 2048);
        checks++;
        if (got >= 1024 || pix_z_a !== ez || pix_col_a !== 5'(ec) || pix_row_a !== 5'(er) || pix_last_a !== (got == 1023)) begin
          errors++;
          $display("FAIL pixel_%0d: z=%0d col=%0d row=%0d last=%b want z=%0d col=%0d row=%0d last=%b",
                   got, pix_z_a, pix_col_a, pix_row_a, pix_last_a, ez, ec, er, got == 1023);
        end
        got++;
      end
      if (poly_ready_a && got >= 1024) done = 1;
      else if (edges > 6000) begin
        errors++; checks++; done = 1;
        $display("FAIL walk_timeout: got %0d pixels want 1024", got);
      end
      prev_stall = pix_valid_a && !pix_ready_a; prev_x = x_ps_a; prev_z = pix_z_a;
      if (!done) begin
        @(negedge clock);
        edges++;
      end
    end
    checks++;
    if (got !== 1024) begin
      errors++; $display("FAIL walk_count: got %0d want 1024", got);
    end
    checks++;
    if (setups !== 32) begin
      errors++; $display("FAIL setup_pulses: got %0d want 32", setups);
    end
    if (exp_cycles > 0) begin
      checks++;
      if (edges !== exp_cycles) begin
        errors++; $display("FAIL tile_cycles: got %0d want %0d", edges, exp_cycles);
      end
    end
  endtask

  task automatic test_reset_mid_tile();
    int n;
    @(negedge clock);
    tile_x_base_a = 11'd64; tile_y_base_a = 11'd32; poly_valid_a = 1'b1; pix_ready_a = 1'b1;
    @(negedge clock);
    poly_valid_a = 1'b0;
    n = 0;
    while (!(x_ps_a == 11'd74 && y_ps_a == 11'd35 && !setup_a && busy_a) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL midtile_reach: never reached row 3 col 10 (x=%0d y=%0d)", x_ps_a, y_ps_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (setup_a !== 1'b0 || pix_valid_a !== 1'b0 || pix_last_a !== 1'b0 || busy_a !== 1'b0 ||
        poly_ready_a !== 1'b1 || x_ps_a !== 11'd0 || y_ps_a !== 11'd0 || pix_col_a !== 5'd0 ||
        pix_row_a !== 5'd0 || pix_z_a !== 32'sd0) begin
      errors++;
      $display("FAIL midtile_reset: setup=%b valid=%b last=%b busy=%b prdy=%b x=%0d y=%0d col=%0d row=%0d z=%0d",
               setup_a, pix_valid_a, pix_last_a, busy_a, poly_ready_a, x_ps_a, y_ps_a, pix_col_a, pix_row_a, pix_z_a);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (pix_valid_a !== 1'b0 || busy_a !== 1'b0 || poly_ready_a !== 1'b1) begin
        errors++;
        $display("FAIL midtile_after: valid=%b busy=%b prdy=%b want 0 0 1", pix_valid_a, busy_a, poly_ready_a);
      end
    end
    walk_tile(64, 32, 1'b0, 1089);
  endtask

  task automatic test_random_ready();
    walk_tile(64, 32, 1'b1, 0);
    pix_ready_a = 1'b1;
  endtask

  task automatic test_wrap();
    walk_tile(2040, 2047, 1'b0, 1089);
  endtask

  task automatic test_back_to_back();
    int n, got, lasts;
    bit seen_last;
    @(negedge clock);
    tile_x_base_a = 11'd100; tile_y_base_a = 11'd200; poly_valid_a = 1'b1; pix_ready_a = 1'b1;
    @(negedge clock);
    tile_x_base_a = 11'd7; tile_y_base_a = 11'd7;
    n = 0; got = 0; seen_last = 0;
    while (!seen_last && n < 3000) begin
      checks++;
      if (busy_a && poly_ready_a) begin
        errors++; $display("FAIL b2b_ready_while_busy: poly_ready=%b busy=%b", poly_ready_a, busy_a);
      end
      if (pix_valid_a && pix_ready_a) begin
        got++;
        if (pix_last_a) seen_last = 1;
      end
      if (seen_last) begin
        tile_x_base_a = 11'd300; tile_y_base_a = 11'd400;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    checks++;
    if (got !== 1024) begin
      errors++; $display("FAIL b2b_first_count: got %0d want 1024", got);
    end
    @(negedge clock);
    checks++;
    if (poly_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: prdy=%b busy=%b want 1 0", poly_ready_a, busy_a);
    end
    @(negedge clock);
    checks++;
    if (poly_ready_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: prdy=%b busy=%b want 0 1", poly_ready_a, busy_a);
    end
    poly_valid_a = 1'b0;
    n = 0; got = 0; lasts = 0;
    while (!(poly_ready_a && got > 0) && n < 3000) begin
      if (pix_valid_a && pix_ready_a) begin
        if (got == 0) begin
          checks++;
          if (pix_z_a !== 32'sd400900 || pix_col_a !== 5'd0 || pix_row_a !== 5'd0 || pix_last_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_pixel: z=%0d col=%0d row=%0d last=%b want 400900 0 0 0",
                     pix_z_a, pix_col_a, pix_row_a, pix_last_a);
          end
        end
        if (pix_last_a) lasts++;
        got++;
      end
      @(negedge clock);
      n++;
    end
    checks++;
    if (got !== 1024 || lasts !== 1) begin
      errors++; $display("FAIL b2b_second_tile: pixels=%0d lasts=%0d want 1024 1", got, lasts);
    end
  endtask

  task automatic test_setup_wait();
    int edges, got, last_setup, ec, er, ez;
    bit done;
    @(negedge clock);
    tile_x_base_b = 11'd10; tile_y_base_b = 11'd20; poly_valid_b = 1'b1; pix_ready_b = 1'b1;
    @(negedge clock);
    poly_valid_b = 1'b0;
    edges = 0; got = 0; last_setup = -100; done = 0;
    while (!done) begin
      if (setup_b) last_setup = edges;
      if (pix_valid_b && pix_ready_b) begin
        ec = got % 8; er = got / 8;
        ez = 3 * (10 + ec) + 1000 * (20 + er);
        checks++;
        if (pix_z_b !== ez || pix_col_b !== 5'(ec) || pix_row_b !== 5'(er) || pix_last_b !== (got == 31)) begin
          errors++;
          $display("FAIL settle_pixel_%0d: z=%0d col=%0d row=%0d last=%b want z=%0d col=%0d row=%0d last=%b",
                   got, pix_z_b, pix_col_b, pix_row_b, pix_last_b, ez, ec, er, got == 31);
        end
        if (ec == 0) begin
          checks++;
          if (edges - last_setup !== 5) begin
            errors++; $display("FAIL settle_gap_row%0d: got %0d want 5", er, edges - last_setup);
          end
        end
        got++;
      end
      if (poly_ready_b && got >= 32) done = 1;
      else if (edges > 500) begin
        errors++; checks++; done = 1;
        $display("FAIL settle_timeout: got %0d pixels want 32", got);
      end
      if (!done) begin
        @(negedge clock);
        edges++;
      end
    end
    checks++;
    if (edges !== 49) begin
      errors++; $display("FAIL settle_cycles: got %0d want 49", edges);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_tile();
    test_random_ready();
    test_wrap();
    test_back_to_back();
    test_setup_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
